// File: rtl/press_decoder_if.sv
// Button-gesture bundle: debounced level in, gesture pulses and status out.
// master drives the button level, slave is the decoder.
interface press_decoder_if #(
  parameter int CNT_W = 26
);
  logic             in;
  logic             short_press;
  logic             long_press;
  logic             double_press;
  logic [CNT_W-1:0] press_len;
  logic             busy;

  modport master (
    output in,
    input  short_press, long_press, double_press, press_len, busy
  );

  modport slave (
    input  in,
    output short_press, long_press, double_press, press_len, busy
  );
endinterface

// File: rtl/press_decoder.sv
// Classifies a debounced button level into short, long and double presses,
// emitting one registered single-cycle pulse per gesture.
//
// state        | meaning
// IDLE         | button released, no gesture in progress
// PRESS1       | first press held, counting high samples
// WAIT_GAP     | first press released, counting low samples for a second press
// WAIT_RELEASE | gesture finished or reset while held; wait for the button to drop
module press_decoder #(
  parameter int  LONG_LEN = 50000000,
  parameter int  GAP_LEN  = 15000000,
  localparam int CNT_W    = $clog2((LONG_LEN > GAP_LEN) ? LONG_LEN : GAP_LEN)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  press_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS1       = 2'd1,
    WAIT_GAP     = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in) begin
          state_d = PRESS1;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS1: begin
        if (bus.in) begin
          if (cnt_q == CNT_W'(LONG_LEN - 1)) begin
            long_d  = 1'b1;
            state_d = WAIT_RELEASE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // the first low sample already counts toward the gap
          len_d   = cnt_q;
          cnt_d   = CNT_W'(1);
          state_d = WAIT_GAP;
        end
      end
      WAIT_GAP: begin
        if (bus.in) begin
          double_d = 1'b1;
          state_d  = WAIT_RELEASE;
        end else if (cnt_q == CNT_W'(GAP_LEN - 1)) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_RELEASE: begin
        if (!bus.in) state_d = IDLE;
      end
      default: state_d = WAIT_RELEASE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= WAIT_RELEASE;
      cnt_q    <= '0;
      len_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.double_press = double_q;
  assign bus.press_len    = len_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_press_decoder.sv
// Directed and randomized gesture sequences for press_decoder, checked each
// cycle against a run-length reference model.
module tb_press_decoder;
  localparam int LONG_LEN = 8;
  localparam int GAP_LEN  = 4;
  localparam int CNT_W    = 3;

  logic clk;
  logic reset;

  press_decoder_if #(.CNT_W(CNT_W)) bus ();

  press_decoder #(
    .LONG_LEN (LONG_LEN),
    .GAP_LEN  (GAP_LEN)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: gesture described by the length of its first high run
  // and of the low run that follows it.
  bit ign, active;
  int h1, g, plen;
  bit e_short, e_long, e_dbl;

  task automatic model_edge(input bit rst, input bit s);
    e_short = 1'b0;
    e_long  = 1'b0;
    e_dbl   = 1'b0;
    if (rst) begin
      ign = 1'b1; active = 1'b0; plen = 0; h1 = 0; g = 0;
    end else if (ign) begin
      if (!s) ign = 1'b0;
    end else if (!active) begin
      if (s) begin active = 1'b1; h1 = 1; g = 0; end
    end else if (g == 0) begin
      if (s) begin
        h1++;
        if (h1 == LONG_LEN) begin e_long = 1'b1; active = 1'b0; ign = 1'b1; end
      end else begin
        plen = h1;
        g    = 1;
      end
    end else begin
      if (s) begin
        e_dbl = 1'b1; active = 1'b0; ign = 1'b1;
      end else begin
        g++;
        if (g == GAP_LEN) begin e_short = 1'b1; active = 1'b0; end
      end
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("short_press",  int'(bus.short_press),  int'(e_short));
    check("long_press",   int'(bus.long_press),   int'(e_long));
    check("double_press", int'(bus.double_press), int'(e_dbl));
    check("press_len",    int'(bus.press_len),    plen);
    check("busy",         int'(bus.busy),         int'(ign | active));
  endtask

  // Apply one sample at the falling edge, let the rising edge take it, check at the next fall.
  task automatic step(input bit s);
    bus.in = s;
    @(posedge clk);
    model_edge(reset, s);
    @(negedge clk);
    check_all();
  endtask

  task automatic seq(input int high, input int low);
    repeat (high) step(1'b1);
    repeat (low)  step(1'b0);
  endtask

  initial begin
    int h, l;
    reset  = 1'b1;
    bus.in = 1'b0;
    step(1'b0);
    reset = 1'b0;
    step(1'b0);
    step(1'b0);

    seq(3, 6);          // short, press_len 3
    seq(7, 6);          // longest short press
    seq(8, 3);          // exactly long
    seq(2, 3);          // double inside window
    seq(2, 6);
    seq(2, 4);          // gap closes: short, then new gesture
    seq(2, 6);
    seq(20, 3);         // one long pulse only
    seq(2, 6);

    // reset in WAIT_GAP with the button held across deassertion
    step(1'b1); step(1'b1); step(1'b0);
    reset = 1'b1;
    step(1'b1); step(1'b1);
    reset = 1'b0;
    step(1'b1); step(1'b1); step(1'b1);
    seq(0, 2);
    seq(2, 6);

    for (int i = 0; i < 80; i++) begin
      h = $urandom_range(1, 12);
      l = $urandom_range(1, 6);
      seq(h, l);
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b1;
        step(1'($urandom_range(0, 1)));
        reset = 1'b0;
      end
    end
    seq(0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/press_decoder.md
Name: press_decoder

Overview:
- Receive-side counterpart to the LED blinker for the user-interface path. Takes a clean, debounced button level, for example from sync_debounce, and classifies each gesture as a short press, a long press or a double press.
- Emits one single-cycle registered pulse per gesture for control logic such as mode select or TX trigger.
- Sits between sync_debounce and the top-level control FSM. Runs on the system clock.

Parameters:
- LONG_LEN, 50000000: consecutive high samples that make a long press (1 s at 50 MHz). Must be >= 2.
- GAP_LEN, 15000000: consecutive low samples after the first release that close the double-press window (0.3 s). Must be >= 2.
- CNT_W, clog2(max(LONG_LEN, GAP_LEN)): counter width, derived via util.vh clog2. Do not override.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- in, input, 1: debounced button level, high = pressed. Must already be synchronous to clk.
- short_press, output, 1: one-cycle pulse for a single short press.
- long_press, output, 1: one-cycle pulse for a long press, asserted while the button is still held.
- double_press, output, 1: one-cycle pulse when a second press starts inside the gap window.
- press_len, output, CNT_W: high-sample count of the most recent first press that ended as short or double.
- busy, output, 1: high whenever state != IDLE.

Behaviour:
- All outputs are registered.
- Reset:
  - state <= WAIT_RELEASE, cnt <= 0.
  - short_press, long_press, double_press and press_len are all 0.
  - busy = 1 out of reset.
  - Reset mid-gesture aborts the gesture with no pulse.
  - A button held through reset is ignored until it is released.
- Pulse outputs default to 0 every cycle. At most one pulse is asserted in any cycle.
- States and transitions, evaluated at each clk edge when reset = 0:
  - IDLE:
    - in = 1 -> PRESS1, cnt <= 1.
    - in = 0 -> stay.
  - PRESS1:
    - in = 1 and cnt == LONG_LEN-1 -> long_press <= 1, go to WAIT_RELEASE.
    - in = 1 otherwise -> cnt <= cnt+1.
    - in = 0 -> press_len <= cnt, go to WAIT_GAP, cnt <= 1.
  - WAIT_GAP:
    - in = 1 -> double_press <= 1, go to WAIT_RELEASE.
    - in = 0 and cnt == GAP_LEN-1 -> short_press <= 1, go to IDLE.
    - in = 0 otherwise -> cnt <= cnt+1.
  - WAIT_RELEASE:
    - in = 0 -> IDLE.
    - in = 1 -> stay, with no further pulses.
- Latency:
  - long_press is high in the cycle after the LONG_LEN-th consecutive high sample.
  - short_press is high in the cycle after the GAP_LEN-th consecutive low sample following release.
  - double_press is high in the cycle after the first high sample inside the gap.
- Boundaries:
  - A press of exactly LONG_LEN-1 samples is short. A press of LONG_LEN samples is long.
  - A gap of GAP_LEN-1 low samples followed by a high sample gives a double press. GAP_LEN low samples give a short press.
  - A third press after a double press is absorbed by WAIT_RELEASE/IDLE and starts a new gesture only after release.
  - The counter never wraps, because it is bounded by the compares.
  - press_len is not updated on a long press and holds its value until the next release from PRESS1.

Test Plan:
All scenarios use LONG_LEN=8 and GAP_LEN=4.
- Reset with in=0: all pulses and press_len are 0, busy=1 for one cycle, then IDLE with busy=0.
- in high for 3 samples, then low: short_press is one cycle high exactly 4 cycles after the first low sample; press_len=3; no other pulse.
- in high for 7 samples, then low: short_press (boundary) and press_len=7. Repeat with 8 high samples: long_press is high in the cycle after the 8th sample while in is still high; nothing happens on release.
- High 2, low 3, high 2, low: one double_press one cycle after the 2nd press starts; press_len=2; no short_press. With low 4 instead of low 3: short_press, and the second press starts a new gesture.
- Hold in=1 for 20 samples: exactly one long_press; no pulse on release; the next 2-sample press produces a short_press.
- Assert reset while in WAIT_GAP and hold in=1 across reset deassertion: no pulse; busy stays 1 until in falls; the next tap decodes normally.
